// File: rtl/paddle_input_ctrl_if.sv
// Button-side bundle for paddle_input_ctrl: raw buttons in, move strobes and held flag out.
// Latency/backpressure: plain wires, no flow control.
interface paddle_input_ctrl_if;
    logic BTN_UP_RAW;
    logic BTN_DOWN_RAW;
    logic up;
    logic down;
    logic held;

    modport master (output BTN_UP_RAW, BTN_DOWN_RAW, input up, down, held);
    modport slave  (input BTN_UP_RAW, BTN_DOWN_RAW, output up, down, held);
endinterface

// File: rtl/paddle_input_ctrl.sv
// Purpose: sync + debounce two buttons, emit single-cycle up/down strobes with auto-repeat.
// Latency: DEBOUNCE_CYCLES+2 cycles press-to-strobe; backpressure: none, strobes are fire-and-forget.
module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 750000,
    parameter int REPEAT_DELAY    = 22500000,
    parameter int REPEAT_PERIOD   = 3750000,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    paddle_input_ctrl_if.slave btn_if
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN} cmd_e;
    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]         raw;
    logic [1:0]         sync1_d, sync1_q;
    logic [1:0]         sync2_d, sync2_q;
    logic [1:0]         db_d, db_q;
    logic [1:0][DW-1:0] cnt_d, cnt_q;

    cmd_e          cmd;
    cmd_e          dir_d, dir_q;
    state_e        state_d, state_q;
    logic [RW-1:0] rep_d, rep_q;
    logic          up_d, up_q;
    logic          down_d, down_q;
    logic          held_d, held_q;

    assign raw = {btn_if.BTN_DOWN_RAW, btn_if.BTN_UP_RAW} ^ {2{BTN_ACTIVE_LOW}};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Both buttons down cancels out to no command.
    always_comb begin
        cmd = CMD_NONE;
        if (db_q[0] && !db_q[1]) begin
            cmd = CMD_UP;
        end else if (db_q[1] && !db_q[0]) begin
            cmd = CMD_DOWN;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rep_d   = rep_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd != CMD_NONE) begin
                    dir_d   = cmd;
                    up_d    = (cmd == CMD_UP);
                    down_d  = (cmd == CMD_DOWN);
                    rep_d   = DELAY_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Any change of command drops back to IDLE silently; IDLE re-arms next cycle.
                if (cmd != dir_q) begin
                    state_d = ST_IDLE;
                end else if (rep_q == '0) begin
                    up_d   = (dir_q == CMD_UP);
                    down_d = (dir_q == CMD_DOWN);
                    rep_d  = PERIOD_LOAD;
                end else begin
                    rep_d = rep_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        held_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            dir_q   <= CMD_NONE;
            rep_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            rep_q   <= rep_d;
            up_q    <= up_d;
            down_q  <= down_d;
            held_q  <= held_d;
        end
    end

    assign btn_if.up   = up_q;
    assign btn_if.down = down_q;
    assign btn_if.held = held_q;
endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Button conditioning stage directly upstream of the paddle position FSM. It synchronises and debounces two raw push-button inputs and produces clean single-cycle `up` / `down` move strobes. While a button is held, it auto-repeats the strobe so the paddle keeps stepping. Each strobe rising edge commands one paddle step of ±1 row.

## Interface
- `DEBOUNCE_CYCLES`, default 750000: consecutive stable samples required to accept a level change (10 ms at 75 MHz); ≥2.
- `REPEAT_DELAY`, default 22500000: cycles from the first strobe to the first repeat strobe (300 ms); ≥2.
- `REPEAT_PERIOD`, default 3750000: cycles between subsequent repeat strobes (50 ms); ≥2.
- `BTN_ACTIVE_LOW`, default 0: 1 means raw buttons read 0 when pressed.
- `CLK` input 1: single clock, 75 MHz.
- `RST` input 1: asynchronous, active-high reset.
- `BTN_UP_RAW` input 1: raw up button, asynchronous to `CLK`.
- `BTN_DOWN_RAW` input 1: raw down button, asynchronous to `CLK`.
- `up` output 1: registered move-up strobe, one cycle per step.
- `down` output 1: registered move-down strobe, one cycle per step.
- `held` output 1: registered; 1 while exactly one debounced button is pressed.

## Operation
- **Polarity.** Raw inputs are XORed with `BTN_ACTIVE_LOW` before synchronisation. Internally, 1 means pressed.
- **Synchronisation.** Each input passes through a 2-FF synchroniser.
- **Debounce (per button).**
  - Keep a debounced level `db` and a counter `cnt`. Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
  - If sync == db: `cnt` ← 0.
  - Else if `cnt` == DEBOUNCE_CYCLES−1: `db` ← sync and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
- **Command decode.** cmd = UP if db_up & !db_dn; DOWN if db_dn & !db_up; NONE otherwise. Both buttons pressed means NONE.
- **Strobe FSM.** One repeat counter, width ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)). States and transitions:
  - IDLE: when cmd ≠ NONE, latch dir ← cmd, assert the strobe for dir, load the counter with REPEAT_DELAY−1, go to WAIT.
  - WAIT: decrement the counter. When it reaches 0 and cmd == dir, assert the strobe, load REPEAT_PERIOD−1, and stay in WAIT.
  - Any state, when cmd ≠ dir (release, both pressed, or direction change): go to IDLE with no strobe that cycle. A new cmd is then served from IDLE on the following cycle as a fresh press.
- **Output rules.**
  - `up` and `down` are never both 1.
  - Each strobe lasts exactly 1 cycle, so the downstream edge-triggered FSM sees one rising edge per step.
  - `held` = (state == WAIT).
- **Reset.**
  - Reset values: sync FFs 0, `db` 0, `cnt` 0, repeat counter 0, state IDLE, `up` 0, `down` 0, `held` 0.
  - Reset asserted mid-repeat clears everything immediately (asynchronously).
  - After reset deassertion, a button that is still held is treated as a new press and needs the full debounce latency.

## Timing
- Let E0 be the first `CLK` edge that samples a new raw level, with the level stable from then on.
- The synchronised value is valid after E1; `db` changes at edge E(DEBOUNCE_CYCLES+1).
- The first strobe is high in the cycle after edge E(DEBOUNCE_CYCLES+2). Press-to-strobe latency is DEBOUNCE_CYCLES+2 cycles.
- For a first strobe at edge P:
  - The first repeat is at P+REPEAT_DELAY.
  - Subsequent repeats are at P+REPEAT_DELAY+k·REPEAT_PERIOD.
- Release: the last possible strobe is at the edge where `db` falls (the FSM still sees the old `db`). No strobe occurs afterwards.
- A raw glitch shorter than DEBOUNCE_CYCLES samples never changes `db` and produces no strobe.

## Test plan
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=0 unless noted.
1. **Held press.** BTN_UP_RAW high for samples E0..E29, then low → `up` pulses at edges 6, 16, 19, 22, 25, 28, 31, 34 (8 pulses); `down` stays 0; `held` falls at edge 36.
2. **Bounce.** BTN_DOWN_RAW toggles high 3 cycles, low 1 cycle, high 2 cycles, then low → no `down` pulse; `db` stays 0.
3. **Both pressed.** Down held until it is repeating, then up pressed → strobes stop once up is debounced. Release up → `down` pulses 1 cycle after up's `db` falls, then repeats after REPEAT_DELAY.
4. **Direction switch.** Release up and press down on the same sample → no strobe for DEBOUNCE_CYCLES+2 cycles, then `down` pulses with no `up` in between.
5. **Reset mid-repeat.** Pulse RST between repeat strobes → outputs go 0 immediately. With up still held, the first `up` strobe comes DEBOUNCE_CYCLES+2 cycles after reset release.
6. **Active-low.** BTN_ACTIVE_LOW=1 with raw inputs idle at 1 → no strobes. Driving BTN_UP_RAW to 0 → `up` at E6.
